// File: rtl/adder_pkg.sv
// ============================================================================
// adder_pkg : shared constants and helpers for the pipelined adder family
// Rev 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

  // Mode select on the sub input
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int seg_width(input int width, input int nstages);
    return width / nstages;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_segment.sv
// ============================================================================
// adder_segment : SEGW-bit combinational full adder with MSB carry-in tap
// Rev 1.0
// ============================================================================
`default_nettype none

module adder_segment #(
  parameter int SEGW = 8
) (
  input  logic [SEGW-1:0] a,
  input  logic [SEGW-1:0] b,
  input  logic            cin,
  output logic [SEGW-1:0] sum,
  output logic            cout,
  output logic            msb_cin
);

  logic [SEGW:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SEGW{1'b0}}, cin};
  assign sum   = total[SEGW-1:0];
  assign cout  = total[SEGW];
  // Carry into the top bit recovered from the sum bit: s = a ^ b ^ c
  assign msb_cin = a[SEGW-1] ^ b[SEGW-1] ^ sum[SEGW-1];

endmodule

`default_nettype wire

// File: rtl/pipelined_adder_nbit.sv
// ============================================================================
// pipelined_adder_nbit : WIDTH-bit add/sub, carry chain cut into NSTAGES regs
// Rev 1.0
// ============================================================================
`default_nettype none

module pipelined_adder_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NSTAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEGW = seg_width(WIDTH, NSTAGES);

  if (NSTAGES < 1 || NSTAGES > WIDTH) begin : g_chk_range
    $error("pipelined_adder_nbit: NSTAGES must be in 1..WIDTH");
  end
  if (WIDTH % NSTAGES != 0) begin : g_chk_div
    $error("pipelined_adder_nbit: WIDTH must be divisible by NSTAGES");
  end

  // Single enable for the whole pipe: a stalled output freezes every stage.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int LO   = k * SEGW;
    localparam int DONE = LO + SEGW;
    localparam int REM  = WIDTH - DONE;

    logic [WIDTH-LO-1:0] opa;
    logic [WIDTH-LO-1:0] opb;
    logic                op_sub;
    logic                seg_cin;
    logic                vld_in;
    logic [DONE-1:0]     res_d;
    logic [SEGW-1:0]     seg_b;
    logic [SEGW-1:0]     seg_sum;
    logic                seg_cout;
    logic                msb_cin_tap;

    logic                vld_q;
    logic                carry_q;
    logic [DONE-1:0]     res_q;

    if (k == 0) begin : g_head
      assign opa     = a;
      assign opb     = b;
      assign op_sub  = sub;
      assign seg_cin = (sub == SUB) ? 1'b1 : cin;
      assign vld_in  = in_valid;
      assign res_d   = seg_sum;
    end else begin : g_body
      assign opa     = g_stage[k-1].g_skew.a_q;
      assign opb     = g_stage[k-1].g_skew.b_q;
      assign op_sub  = g_stage[k-1].g_skew.sub_q;
      assign seg_cin = g_stage[k-1].carry_q;
      assign vld_in  = g_stage[k-1].vld_q;
      assign res_d   = {seg_sum, g_stage[k-1].res_q};
    end

    assign seg_b = (op_sub == SUB) ? ~opb[SEGW-1:0] : opb[SEGW-1:0];

    adder_segment #(
      .SEGW (SEGW)
    ) u_seg (
      .a       (opa[SEGW-1:0]),
      .b       (seg_b),
      .cin     (seg_cin),
      .sum     (seg_sum),
      .cout    (seg_cout),
      .msb_cin (msb_cin_tap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q   <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else if (adv) begin
        vld_q   <= vld_in;
        carry_q <= seg_cout;
        res_q   <= res_d;
      end
    end

    // Operand bits still waiting for a later segment, plus the op's mode.
    if (k < NSTAGES - 1) begin : g_skew
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;
      logic           sub_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
        end else if (adv) begin
          a_q   <= opa[WIDTH-LO-1:SEGW];
          b_q   <= opb[WIDTH-LO-1:SEGW];
          sub_q <= op_sub;
        end
      end
    end

    if (k == NSTAGES - 1) begin : g_tail
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= msb_cin_tap ^ seg_cout;
        end
      end
    end else begin : g_mid
      // Only the MSB segment's carry-in tap feeds overflow.
      logic unused_msb_cin;
      assign unused_msb_cin = msb_cin_tap;
    end
  end

  assign out_valid = g_stage[NSTAGES-1].vld_q;
  assign sum       = g_stage[NSTAGES-1].res_q;
  assign cout      = g_stage[NSTAGES-1].carry_q;
  assign ovf       = g_stage[NSTAGES-1].g_tail.ovf_q;

endmodule

`default_nettype wire
